freq_divi: RTL and testbench

- Selectable integer clock-enable-style divider. Derives a square wave `out` from the 100 MHz system `clock`.
- `sel` chooses one of four division ratios.
- Used to generate slow timing/strobe clocks for downstream logic.
- Fully synchronous to `clock`; no negedge logic and no gated clocks. `out` is a registered signal.

---
 rtl/freq_divi.sv | 111 +++++++++++
 tb/tb_freq_divi.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/freq_divi.sv
// freq_divi: selectable integer divider producing a registered square wave on out.
// Defining FREQ_DIVI_TICK_EN adds a one-cycle tick output coincident with each rise of out.
module freq_divi #(
   parameter int DIV0 = 2,
   parameter int DIV1 = 4,
   parameter int DIV2 = 10,
   parameter int DIV3 = 100,
   parameter int CW   = 7
) (
   input  logic       clock,
   input  logic       rst,
   input  logic [1:0] sel,
`ifdef FREQ_DIVI_TICK_EN
   output logic       tick,
`endif
   output logic       out
);

   // Odd ratios put the extra cycle in the low phase.
   localparam int HIGH0 = DIV0 / 2;
   localparam int HIGH1 = DIV1 / 2;
   localparam int HIGH2 = DIV2 / 2;
   localparam int HIGH3 = DIV3 / 2;
   localparam int LOW0  = DIV0 - HIGH0;
   localparam int LOW1  = DIV1 - HIGH1;
   localparam int LOW2  = DIV2 - HIGH2;
   localparam int LOW3  = DIV3 - HIGH3;

   logic          armed_r;
   logic [1:0]    act_sel_r;
   logic [CW-1:0] cnt_r;
   logic          out_r;
   logic [CW-1:0] low_lim_s;
   logic [CW-1:0] high_lim_s;

   // terminal counts of both phases for the latched ratio
   always_comb begin
      low_lim_s  = CW'(LOW0 - 1);
      high_lim_s = CW'(HIGH0 - 1);
      case (act_sel_r)
         2'd0: begin
            low_lim_s  = CW'(LOW0 - 1);
            high_lim_s = CW'(HIGH0 - 1);
         end
         2'd1: begin
            low_lim_s  = CW'(LOW1 - 1);
            high_lim_s = CW'(HIGH1 - 1);
         end
         2'd2: begin
            low_lim_s  = CW'(LOW2 - 1);
            high_lim_s = CW'(HIGH2 - 1);
         end
         2'd3: begin
            low_lim_s  = CW'(LOW3 - 1);
            high_lim_s = CW'(HIGH3 - 1);
         end
         default: begin
            low_lim_s  = CW'(LOW0 - 1);
            high_lim_s = CW'(HIGH0 - 1);
         end
      endcase
   end

   // arming, phase counting and output; sel is taken only when a period closes
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         armed_r   <= 1'b0;
         act_sel_r <= 2'd0;
         cnt_r     <= '0;
         out_r     <= 1'b0;
      end else if (!armed_r) begin
         armed_r   <= 1'b1;
         act_sel_r <= sel;
         cnt_r     <= '0;
         out_r     <= 1'b0;
      end else if (!out_r) begin
         if (cnt_r == low_lim_s) begin
            out_r <= 1'b1;
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end else begin
         if (cnt_r == high_lim_s) begin
            out_r     <= 1'b0;
            cnt_r     <= '0;
            act_sel_r <= sel;
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

   assign out = out_r;

`ifdef FREQ_DIVI_TICK_EN
   logic tick_r;

   // pulse on the same edge that raises out
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         tick_r <= 1'b0;
      end else begin
         tick_r <= armed_r & ~out_r & (cnt_r == low_lim_s);
      end
   end

   assign tick = tick_r;
`endif

endmodule

// File: tb/tb_freq_divi.sv
// tb_freq_divi: directed and randomised sel sequences; a period-position model feeds
// expected out/tick values through a scoreboard queue, compared one cycle at a time.
module tb_freq_divi;

   logic       clock;
   logic       rst;
   logic [1:0] sel;
   logic       out;
`ifdef FREQ_DIVI_TICK_EN
   logic       tick;
   logic       exp_tick_q[$];
`endif

   int   total = 0;
   int   bad   = 0;
   logic exp_out_q[$];

   // model: position within the current period and that period's ratio
   bit   m_armed   = 1'b0;
   int   m_pos     = 0;
   int   m_n       = 2;
   bit   track_min = 1'b0;
   logic prev_out  = 1'b0;
   int   run_len   = 0;

   freq_divi dut (
      .clock (clock),
      .rst   (rst),
      .sel   (sel),
`ifdef FREQ_DIVI_TICK_EN
      .tick  (tick),
`endif
      .out   (out)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic int div_of(input logic [1:0] s);
      case (s)
         2'd0:    return 2;
         2'd1:    return 4;
         2'd2:    return 10;
         default: return 100;
      endcase
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   // advance the model for the coming edge, push its prediction, then compare after the edge
   task automatic step();
      int low;
      if (rst) begin
         m_armed = 1'b0;
      end else if (!m_armed) begin
         m_armed = 1'b1;
         m_pos   = 0;
         m_n     = div_of(sel);
      end else begin
         m_pos++;
         if (m_pos == m_n) begin
            m_pos = 0;
            m_n   = div_of(sel);
         end
      end
      low = m_n - m_n / 2;
      exp_out_q.push_back(m_armed && (m_pos >= low));
`ifdef FREQ_DIVI_TICK_EN
      exp_tick_q.push_back(m_armed && (m_pos == low));
`endif
      @(posedge clock);
      #1;
      chk("out", out, exp_out_q.pop_front());
`ifdef FREQ_DIVI_TICK_EN
      chk("tick", tick, exp_tick_q.pop_front());
`endif
      if (out !== prev_out) begin
         if (track_min) chk("min_phase", logic'(run_len >= 2), 1'b1);
         run_len = 1;
      end else begin
         run_len++;
      end
      prev_out = out;
   endtask

   initial begin
      rst = 1'b1;
      sel = 2'd3;
      #6;
      chk("reset_out", out, 1'b0);
`ifdef FREQ_DIVI_TICK_EN
      chk("reset_tick", tick, 1'b0);
`endif
      #4;
      rst = 1'b0;
      chk("release_out", out, 1'b0);

      // 1 MHz, then 10 MHz and 25 MHz picked up at period boundaries
      repeat (250) step();
      sel = 2'd2;
      repeat (200) step();
      sel = 2'd1;
      repeat (80) step();

      // synchronous-edge reset, then 50 MHz from the arming edge
      rst = 1'b1;
      repeat (3) step();
      sel = 2'd0;
      rst = 1'b0;
      repeat (20) step();

      // change 3 -> 1 well into the high phase of a 100-cycle period
      sel = 2'd3;
      for (int i = 0; i < 300 && !(m_n == 100 && m_pos >= 60); i++) step();
      chk("reached_high", out, 1'b1);
      track_min = 1'b1;
      sel = 2'd1;
      repeat (120) step();
      track_min = 1'b0;

      // asynchronous reset between edges while out is high
      for (int i = 0; i < 50 && !(m_armed && m_pos >= m_n - m_n / 2); i++) step();
      chk("pre_rst_high", out, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_out", out, 1'b0);
`ifdef FREQ_DIVI_TICK_EN
      chk("async_rst_tick", tick, 1'b0);
`endif
      repeat (3) step();
      sel = 2'd3;
      rst = 1'b0;
      repeat (160) step();

      // random select changes at arbitrary points
      repeat (12) begin
         sel = 2'($urandom_range(0, 3));
         repeat ($urandom_range(5, 60)) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
